// File: rtl/pattern_stream_gen_if.sv
// pattern_stream_gen_if
// Valid/ready stream bundle carrying one DATA_W-bit word per beat.
//   tdata  : beat payload
//   tvalid : source has a beat on the bus
//   tready : sink accepts the beat this cycle
//   tlast  : beat closes a pattern pass
// master modport is the source side, slave modport the sink side.
interface pattern_stream_gen_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/pattern_stream_gen.sv
// pattern_stream_gen
// Plays a compile-time table of words onto a valid/ready stream. Each word
// is repeated cfg_hold beats, a pass covers cfg_len words, and cfg_reps
// passes are played (0 = loop until stop).
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   start, stop       : single-cycle run request / abort request
//   cfg_len/hold/reps : run configuration, sampled on the accepted start
//   m                 : stream source (tdata/tvalid/tready/tlast)
//   busy              : high while running
//   done              : one-cycle pulse when a run completes or is aborted
module pattern_stream_gen #(
  parameter int DATA_W  = 8,
  parameter int PAT_LEN = 16,
  parameter logic [PAT_LEN-1:0][DATA_W-1:0] PATTERN = '0,
  parameter int HOLD_W  = 16,
  parameter int REP_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic [$clog2(PAT_LEN+1)-1:0] cfg_len,
  input  logic [HOLD_W-1:0]          cfg_hold,
  input  logic [REP_W-1:0]           cfg_reps,
  pattern_stream_gen_if.master       m,
  output logic                       busy,
  output logic                       done
);
  localparam int LEN_W = $clog2(PAT_LEN + 1);
  localparam int IDX_W = $clog2(PAT_LEN);
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(PAT_LEN);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [REP_W-1:0]  REP_ONE  = REP_W'(1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_reg;
  logic [LEN_W-1:0]    len_reg;
  logic [HOLD_W-1:0]   hold_reg;
  logic [REP_W-1:0]    reps_reg;
  logic [IDX_W-1:0]    word_idx_reg;
  logic [HOLD_W-1:0]   hold_cnt_reg;
  logic [REP_W-1:0]    pass_cnt_reg;
  logic                stop_pend_reg;
  logic [DATA_W-1:0]   tdata_reg;
  logic                tvalid_reg;
  logic                tlast_reg;
  logic                busy_reg;
  logic                done_reg;

  // Unpacked view of the pattern table for indexed lookup.
  logic [DATA_W-1:0] pat_word [PAT_LEN];
  for (genvar gi = 0; gi < PAT_LEN; gi++) begin : g_pat
    assign pat_word[gi] = PATTERN[gi];
  end

  logic [LEN_W-1:0]  len_cfg;
  logic [HOLD_W-1:0] hold_cfg;
  logic              xfer, hold_end, word_end, final_pass, finish;
  logic [HOLD_W-1:0] hold_next;
  logic [IDX_W-1:0]  idx_next;
  logic [REP_W-1:0]  pass_next;
  logic              tlast_next;

  always_comb begin
    len_cfg  = (cfg_len == '0 || cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
    hold_cfg = (cfg_hold == '0) ? HOLD_ONE : cfg_hold;
  end

  always_comb begin
    xfer       = tvalid_reg & m.tready;
    hold_end   = (hold_cnt_reg == hold_reg - HOLD_ONE);
    word_end   = (LEN_W'(word_idx_reg) == len_reg - LEN_ONE);
    final_pass = (reps_reg != '0) && (pass_cnt_reg == reps_reg - REP_ONE);
    // A pending or same-cycle stop makes the beat being accepted the last one.
    finish     = xfer && ((hold_end && word_end && final_pass) || stop_pend_reg || stop);
  end

  // Counter positions after the current beat is accepted; the output
  // registers are loaded from these so tdata/tlast track the new position.
  always_comb begin
    hold_next = hold_cnt_reg;
    idx_next  = word_idx_reg;
    pass_next = pass_cnt_reg;
    if (hold_end) begin
      hold_next = '0;
      if (word_end) begin
        idx_next = '0;
        // Saturate so an endless run cannot wrap the pass counter.
        if (pass_cnt_reg != '1) pass_next = pass_cnt_reg + REP_ONE;
      end else begin
        idx_next = word_idx_reg + IDX_ONE;
      end
    end else begin
      hold_next = hold_cnt_reg + HOLD_ONE;
    end
    tlast_next = (hold_next == hold_reg - HOLD_ONE) &&
                 (LEN_W'(idx_next) == len_reg - LEN_ONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      hold_reg      <= '0;
      reps_reg      <= '0;
      word_idx_reg  <= '0;
      hold_cnt_reg  <= '0;
      pass_cnt_reg  <= '0;
      stop_pend_reg <= 1'b0;
      tdata_reg     <= '0;
      tvalid_reg    <= 1'b0;
      tlast_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          stop_pend_reg <= 1'b0;
          if (start && !stop) begin
            state_reg    <= RUN;
            len_reg      <= len_cfg;
            hold_reg     <= hold_cfg;
            reps_reg     <= cfg_reps;
            word_idx_reg <= '0;
            hold_cnt_reg <= '0;
            pass_cnt_reg <= '0;
            tdata_reg    <= pat_word[0];
            tvalid_reg   <= 1'b1;
            tlast_reg    <= (hold_cfg == HOLD_ONE) && (len_cfg == LEN_ONE);
            busy_reg     <= 1'b1;
          end
        end
        RUN: begin
          if (finish) begin
            state_reg     <= IDLE;
            word_idx_reg  <= '0;
            hold_cnt_reg  <= '0;
            pass_cnt_reg  <= '0;
            stop_pend_reg <= 1'b0;
            tdata_reg     <= '0;
            tvalid_reg    <= 1'b0;
            tlast_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
          end else begin
            if (stop) stop_pend_reg <= 1'b1;
            if (xfer) begin
              hold_cnt_reg <= hold_next;
              word_idx_reg <= idx_next;
              pass_cnt_reg <= pass_next;
              tdata_reg    <= pat_word[idx_next];
              tlast_reg    <= tlast_next;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign m.tdata  = tdata_reg;
  assign m.tvalid = tvalid_reg;
  assign m.tlast  = tlast_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
endmodule

// File: tb/tb_pattern_stream_gen.sv
// tb_pattern_stream_gen
// Directed and randomized runs of pattern_stream_gen with PATTERN[i] = i.
// Expected beats are computed arithmetically from the beat index and the
// clamped configuration; one line is printed per accepted beat.
module tb_pattern_stream_gen;
  localparam int DATA_W  = 8;
  localparam int PAT_LEN = 16;
  localparam int HOLD_W  = 16;
  localparam int REP_W   = 8;
  localparam int LEN_W   = 5;
  localparam logic [PAT_LEN-1:0][DATA_W-1:0] PAT = {
    8'h0f, 8'h0e, 8'h0d, 8'h0c, 8'h0b, 8'h0a, 8'h09, 8'h08,
    8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic [HOLD_W-1:0] cfg_hold = '0;
  logic [REP_W-1:0]  cfg_reps = '0;
  logic              busy, done;

  pattern_stream_gen_if #(.DATA_W(DATA_W)) s_if ();

  pattern_stream_gen #(
    .DATA_W(DATA_W), .PAT_LEN(PAT_LEN), .PATTERN(PAT),
    .HOLD_W(HOLD_W), .REP_W(REP_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .cfg_len(cfg_len), .cfg_hold(cfg_hold), .cfg_reps(cfg_reps),
    .m(s_if), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  string tname  = "init";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0h expected=%0h", tname, tag, obs, exp);
    end
  endtask

  function automatic int eff_len(input int l);
    return (l == 0 || l > PAT_LEN) ? PAT_LEN : l;
  endfunction
  function automatic int eff_hold(input int h);
    return (h == 0) ? 1 : h;
  endfunction

  task automatic check_idle_outputs(input bit exp_done);
    check("tvalid_idle", 32'(s_if.tvalid), 0);
    check("tdata_idle",  32'(s_if.tdata), 0);
    check("tlast_idle",  32'(s_if.tlast), 0);
    check("busy_idle",   32'(busy), 0);
    check("done_idle",   32'(done), 32'(exp_done));
  endtask

  // mode: 0 = always ready, 1 = ready toggles starting high, 2 = random.
  // stop_at: beat index presented when stop is pulsed (-1 = never).
  // reset_at: beat index presented when reset is asserted (-1 = never).
  task automatic run(input int len, input int hold, input int reps, input int mode,
                     input int stop_at, input bit stop_rdy, input int reset_at);
    int L, H, total, k, cyc;
    bit rdy, stop_done, restart_done;
    L = eff_len(len);
    H = eff_hold(hold);
    total = (reps == 0) ? 32'h3fffffff : reps * L * H;
    if (stop_at >= 0 && stop_at + 1 < total) total = stop_at + 1;
    rdy = 1'b0;
    stop_done = 1'b0;
    restart_done = 1'b0;
    @(negedge clk);
    cfg_len  = LEN_W'(len);
    cfg_hold = HOLD_W'(hold);
    cfg_reps = REP_W'(reps);
    start = 1'b1;
    s_if.tready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("busy_on", 32'(busy), 1);
    k = 0;
    cyc = 0;
    while (k < total && cyc < 4000) begin
      check("tvalid", 32'(s_if.tvalid), 1);
      check("tdata",  32'(s_if.tdata), 32'((k / H) % L));
      check("tlast",  32'(s_if.tlast), 32'((k % (L * H)) == L * H - 1));
      check("done_low", 32'(done), 0);
      if (k == reset_at) begin
        reset = 1'b1;
        #1;
        check_idle_outputs(1'b0);
        @(negedge clk);
        reset = 1'b0;
        check_idle_outputs(1'b0);
        return;
      end
      start = 1'b0;
      stop  = 1'b0;
      if (k == 1 && k < total && !restart_done) begin
        // Start and new config while running must be ignored.
        start = 1'b1;
        cfg_len = LEN_W'(1);
        cfg_hold = HOLD_W'(7);
        restart_done = 1'b1;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ~rdy;
        default: rdy = 1'($urandom % 2);
      endcase
      if (k == stop_at && !stop_done) begin
        stop = 1'b1;
        rdy = stop_rdy;
        stop_done = 1'b1;
      end
      s_if.tready = rdy;
      if (rdy && s_if.tvalid) begin
        $display("%s beat %0d data=%02h last=%0d", tname, k, s_if.tdata, s_if.tlast);
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    stop = 1'b0;
    s_if.tready = 1'b0;
    check("beats_done", 32'(k), 32'(total));
    check_idle_outputs(1'b1);
    @(negedge clk);
    check("done_pulse_end", 32'(done), 0);
    check("tvalid_after", 32'(s_if.tvalid), 0);
  endtask

  initial begin
    s_if.tready = 1'b0;
    #1;
    tname = "reset";
    check_idle_outputs(1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_idle_outputs(1'b0);

    tname = "t1_len4";
    run(4, 1, 1, 0, -1, 1'b0, -1);
    tname = "t2_hold3";
    run(2, 3, 2, 0, -1, 1'b0, -1);
    tname = "t3_toggle";
    run(2, 3, 2, 1, -1, 1'b0, -1);
    tname = "t4_loop_stop";
    run(3, 1, 0, 0, 25, 1'b0, -1);
    tname = "t4b_stop_on_last";
    run(4, 1, 1, 0, 3, 1'b1, -1);
    tname = "t5_reset";
    run(16, 1, 1, 0, -1, 1'b0, 5);
    tname = "t5_restart";
    run(8, 1, 1, 0, -1, 1'b0, -1);
    tname = "t6_clamp0";
    run(0, 0, 1, 0, -1, 1'b0, -1);
    tname = "t6_clamp20";
    run(20, 1, 1, 2, -1, 1'b0, -1);

    tname = "t6_start_stop";
    @(negedge clk);
    cfg_len = LEN_W'(4);
    cfg_hold = HOLD_W'(1);
    cfg_reps = REP_W'(1);
    start = 1'b1;
    stop = 1'b1;
    s_if.tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_idle_outputs(1'b0);
      @(negedge clk);
    end
    s_if.tready = 1'b0;

    for (int r = 0; r < 6; r++) begin
      int len, hold, reps, L, H, sa;
      len  = int'($urandom_range(0, 20));
      hold = int'($urandom_range(0, 3));
      reps = int'($urandom_range(0, 3));
      L = eff_len(len);
      H = eff_hold(hold);
      if (reps == 0) sa = int'($urandom_range(0, 40));
      else if ($urandom % 2 == 1) sa = int'($urandom_range(0, reps * L * H - 1));
      else sa = -1;
      tname = $sformatf("rand%0d_len%0d_hold%0d_reps%0d_stop%0d", r, len, hold, reps, sa);
      run(len, hold, reps, 2, sa, 1'($urandom % 2), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
